serdes_tx_link_ctrl: RTL

//   Sequences the 5-lane LVDS byte serializer. Owns lane enable (serd_cmd), link

---
 rtl/serdes_tx_link_ctrl_if.sv | 22 ++
 rtl/serdes_tx_link_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serdes_tx_link_ctrl_if.sv
// Upstream word handshake plus the serializer-facing word and lane-group disable bus.
// tx_ready is combinational from the controller; ser_data/serd_cmd are registered.
interface serdes_tx_link_ctrl_if #(
    parameter int LANES = 5
);
    logic               tx_valid;
    logic [8*LANES-1:0] tx_data;
    logic               tx_last;
    logic               tx_ready;
    logic [8*LANES-1:0] ser_data;
    logic [1:0]         serd_cmd;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, ser_data, serd_cmd
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, ser_data, serd_cmd
    );
endinterface

// File: rtl/serdes_tx_link_ctrl.sv
// LVDS TX link sequencer: lane enable, training fill, SOF/payload/EOF framing, idle gaps.
// One-cycle registered output latency; tx_ready only in DATA with link_en high (no skid).
module serdes_tx_link_ctrl #(
    parameter int LANES        = 5,
    parameter int TRAIN_CYCLES = 64,
    parameter int MAX_WORDS    = 256,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_link_en,
    serdes_tx_link_ctrl_if.slave bus,
    output logic                 o_link_up,
    output logic [15:0]          o_frame_cnt,
    output logic                 o_err_overlen,
    output logic                 o_err_underrun
);
    localparam int DW  = 8 * LANES;
    localparam int TCW = $clog2(TRAIN_CYCLES + 1);
    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [DW-1:0] W_IDLE  = {LANES{8'h7E}};
    localparam logic [DW-1:0] W_SOF   = {LANES{8'hFB}};
    localparam logic [DW-1:0] W_EOF   = {LANES{8'hFD}};
    localparam logic [DW-1:0] W_ABORT = {LANES{8'hFE}};

    typedef enum logic [2:0] {
        S_OFF, S_TRAIN, S_IDLE, S_SOF, S_DATA, S_EOF, S_ABORT, S_GAP
    } state_t;

    state_t         r_state,        w_state_nxt;
    logic [TCW-1:0] r_train_cnt,    w_train_cnt_nxt;
    logic [WCW-1:0] r_word_cnt,     w_word_cnt_nxt;
    logic [GCW-1:0] r_gap_cnt,      w_gap_cnt_nxt;
    logic           r_gap_off,      w_gap_off_nxt;
    logic [DW-1:0]  r_ser_data,     w_ser_data_nxt;
    logic [1:0]     r_serd_cmd,     w_serd_cmd_nxt;
    logic [15:0]    r_frame_cnt,    w_frame_cnt_nxt;
    logic           r_err_overlen,  w_err_overlen_nxt;
    logic           r_err_underrun, w_err_underrun_nxt;

    logic           w_tx_ready;
    logic           w_hs;
    logic [WCW-1:0] w_word_cnt_inc;

    // Gated by reset_n so a word offered in the reset cycle is never consumed and dropped.
    assign w_tx_ready     = (r_state == S_DATA) && i_link_en && reset_n;
    assign w_hs           = w_tx_ready && bus.tx_valid;
    assign w_word_cnt_inc = r_word_cnt + 1'b1;

    always_comb begin
        w_state_nxt        = r_state;
        w_train_cnt_nxt    = r_train_cnt;
        w_word_cnt_nxt     = r_word_cnt;
        w_gap_cnt_nxt      = r_gap_cnt;
        w_gap_off_nxt      = r_gap_off;
        w_ser_data_nxt     = W_IDLE;
        w_serd_cmd_nxt     = 2'b00;
        w_frame_cnt_nxt    = r_frame_cnt;
        w_err_overlen_nxt  = 1'b0;
        w_err_underrun_nxt = 1'b0;

        case (r_state)
            S_OFF: begin
                w_serd_cmd_nxt  = 2'b11;
                w_train_cnt_nxt = '0;
                if (i_link_en) w_state_nxt = S_TRAIN;
            end
            S_TRAIN: begin
                if (!i_link_en) begin
                    w_state_nxt = S_OFF;
                end else if (r_train_cnt == TCW'(TRAIN_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_train_cnt_nxt = r_train_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (!i_link_en)        w_state_nxt = S_OFF;
                else if (bus.tx_valid) w_state_nxt = S_SOF;
            end
            S_SOF: begin
                if (!i_link_en) begin
                    w_state_nxt = S_OFF;
                end else begin
                    w_ser_data_nxt = W_SOF;
                    w_word_cnt_nxt = '0;
                    w_state_nxt    = S_DATA;
                end
            end
            S_DATA: begin
                if (!i_link_en) begin
                    w_state_nxt = S_ABORT;
                end else if (w_hs) begin
                    w_ser_data_nxt = bus.tx_data;
                    w_word_cnt_nxt = w_word_cnt_inc;
                    if (bus.tx_last) begin
                        w_state_nxt = S_EOF;
                    end else if (w_word_cnt_inc == WCW'(MAX_WORDS)) begin
                        // The word that hits the limit is the final payload word.
                        w_err_overlen_nxt = 1'b1;
                        w_state_nxt       = S_EOF;
                    end
                end else begin
                    w_err_underrun_nxt = 1'b1;
                end
            end
            S_EOF: begin
                w_ser_data_nxt  = W_EOF;
                w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                w_gap_cnt_nxt   = '0;
                w_gap_off_nxt   = !i_link_en;
                w_state_nxt     = S_GAP;
            end
            S_ABORT: begin
                w_ser_data_nxt = W_ABORT;
                w_gap_cnt_nxt  = '0;
                w_gap_off_nxt  = 1'b1;
                w_state_nxt    = S_GAP;
            end
            S_GAP: begin
                // A shutdown request during the gap is remembered and honoured once it ends.
                if (!i_link_en) w_gap_off_nxt = 1'b1;
                if (r_gap_cnt == GCW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = (r_gap_off || !i_link_en) ? S_OFF : S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_OFF;
            r_train_cnt    <= '0;
            r_word_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_gap_off      <= 1'b0;
            r_ser_data     <= W_IDLE;
            r_serd_cmd     <= 2'b11;
            r_frame_cnt    <= '0;
            r_err_overlen  <= 1'b0;
            r_err_underrun <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_train_cnt    <= w_train_cnt_nxt;
            r_word_cnt     <= w_word_cnt_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_gap_off      <= w_gap_off_nxt;
            r_ser_data     <= w_ser_data_nxt;
            r_serd_cmd     <= w_serd_cmd_nxt;
            r_frame_cnt    <= w_frame_cnt_nxt;
            r_err_overlen  <= w_err_overlen_nxt;
            r_err_underrun <= w_err_underrun_nxt;
        end
    end

    assign bus.tx_ready   = w_tx_ready;
    assign bus.ser_data   = r_ser_data;
    assign bus.serd_cmd   = r_serd_cmd;
    assign o_link_up      = (r_state == S_IDLE) || (r_state == S_SOF) || (r_state == S_DATA) ||
                            (r_state == S_EOF)  || (r_state == S_GAP);
    assign o_frame_cnt    = r_frame_cnt;
    assign o_err_overlen  = r_err_overlen;
    assign o_err_underrun = r_err_underrun;
endmodule
